// File: rtl/axicb_pkg.sv
// Shared encodings for the crossbar slave-side switches: AXI read
// response codes and the state enums of the grant lock and DECERR responder.
package axicb_pkg;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_t;

  typedef enum logic {
    DE_IDLE = 1'b0,
    DE_RESP = 1'b1
  } decerr_state_t;

endpackage

// File: rtl/axicb_slv_decerr.sv
// Internal responder for reads that hit no slave range: answers each
// accepted AR with ARLEN+1 zero-data beats flagged DECERR.
module axicb_slv_decerr
  import axicb_pkg::*;
#(
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 8
)(
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             srst,
  input  logic                             ar_valid_i,
  output logic                             ar_ready_o,
  input  logic [AXI_ID_W-1:0]              ar_id_i,
  input  logic [7:0]                       ar_len_i,
  output logic                             r_valid_o,
  input  logic                             r_ready_i,
  output logic                             r_last_o,
  output logic [AXI_ID_W+AXI_DATA_W+1:0]   r_ch_o
);

  decerr_state_t         state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            len_q, len_d;
  logic [AXI_ID_W-1:0]   id_q, id_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= DE_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
    end else if (srst) begin
      state_q <= DE_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      id_q    <= id_d;
    end
  end

  // The last beat is found by comparing against the captured length, so an
  // 8-bit counter covers ARLEN=255 without wrapping before rlast.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    id_d       = id_q;
    ar_ready_o = (state_q == DE_IDLE);
    r_valid_o  = (state_q == DE_RESP);
    r_last_o   = (state_q == DE_RESP) && (cnt_q == len_q);
    case (state_q)
      DE_IDLE: begin
        if (ar_valid_i) begin
          state_d = DE_RESP;
          id_d    = ar_id_i;
          len_d   = ar_len_i;
          cnt_d   = '0;
        end
      end
      DE_RESP: begin
        if (r_ready_i) begin
          if (r_last_o) begin
            state_d = DE_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  assign r_ch_o = {RRESP_DECERR, {AXI_DATA_W{1'b0}}, id_q};

endmodule

// File: rtl/axicb_slv_switch_rd.sv
// Slave-side read switch: decodes AR onto up to four slaves (or the DECERR
// responder) and round-robin arbitrates whole R bursts back to the master.
module axicb_slv_switch_rd
  import axicb_pkg::*;
#(
  parameter int          AXI_ADDR_W      = 8,
  parameter int          AXI_ID_W        = 8,
  parameter int          AXI_DATA_W      = 8,
  parameter int          SLV_NB          = 4,
  parameter logic [63:0] SLV0_START_ADDR = 64'h0000,
  parameter logic [63:0] SLV0_END_ADDR   = 64'h0FFF,
  parameter logic [63:0] SLV1_START_ADDR = 64'h1000,
  parameter logic [63:0] SLV1_END_ADDR   = 64'h1FFF,
  parameter logic [63:0] SLV2_START_ADDR = 64'h2000,
  parameter logic [63:0] SLV2_END_ADDR   = 64'h2FFF,
  parameter logic [63:0] SLV3_START_ADDR = 64'h3000,
  parameter logic [63:0] SLV3_END_ADDR   = 64'h3FFF,
  parameter int          ARCH_W          = AXI_ADDR_W + AXI_ID_W + 8,
  parameter int          RCH_W           = AXI_ID_W + AXI_DATA_W + 2
)(
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic                     i_arvalid,
  output logic                     i_arready,
  input  logic [ARCH_W-1:0]        i_arch,
  output logic                     i_rvalid,
  input  logic                     i_rready,
  output logic                     i_rlast,
  output logic [RCH_W-1:0]         i_rch,
  output logic [SLV_NB-1:0]        o_arvalid,
  input  logic [SLV_NB-1:0]        o_arready,
  output logic [ARCH_W-1:0]        o_arch,
  input  logic [SLV_NB-1:0]        o_rvalid,
  output logic [SLV_NB-1:0]        o_rready,
  input  logic [SLV_NB-1:0]        o_rlast,
  input  logic [SLV_NB*RCH_W-1:0]  o_rch
);

  localparam int NREQ  = SLV_NB + 1;
  localparam int IDX_W = $clog2(NREQ);

  localparam logic [63:0] START_A [4] = '{SLV0_START_ADDR, SLV1_START_ADDR,
                                          SLV2_START_ADDR, SLV3_START_ADDR};
  localparam logic [63:0] END_A   [4] = '{SLV0_END_ADDR, SLV1_END_ADDR,
                                          SLV2_END_ADDR, SLV3_END_ADDR};

  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_ID_W-1:0]   arid;
  logic [7:0]            arlen;
  logic [SLV_NB-1:0]     sel;
  logic                  miss;

  assign araddr = i_arch[0 +: AXI_ADDR_W];
  assign arid   = i_arch[AXI_ADDR_W +: AXI_ID_W];
  assign arlen  = i_arch[AXI_ADDR_W+AXI_ID_W +: 8];

  // Walk downwards so the lowest matching slave is the one left selected.
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int k = SLV_NB-1; k >= 0; k--) begin
      if (64'(araddr) >= START_A[k] && 64'(araddr) <= END_A[k]) begin
        sel    = '0;
        sel[k] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

  logic                            de_ar_ready;
  logic                            de_r_valid;
  logic                            de_r_ready;
  logic                            de_r_last;
  logic [AXI_ID_W+AXI_DATA_W+1:0]  de_r_ch;

  axicb_slv_decerr #(
    .AXI_ID_W   (AXI_ID_W),
    .AXI_DATA_W (AXI_DATA_W)
  ) u_decerr (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .srst       (srst),
    .ar_valid_i (i_arvalid & miss),
    .ar_ready_o (de_ar_ready),
    .ar_id_i    (arid),
    .ar_len_i   (arlen),
    .r_valid_o  (de_r_valid),
    .r_ready_i  (de_r_ready),
    .r_last_o   (de_r_last),
    .r_ch_o     (de_r_ch)
  );

  assign o_arch    = i_arch;
  assign o_arvalid = {SLV_NB{i_arvalid}} & sel;
  assign i_arready = miss ? de_ar_ready : |(o_arready & sel);

  // Requester SLV_NB is the DECERR responder.
  logic [NREQ-1:0]             req_vld;
  logic [NREQ-1:0]             req_last;
  logic [NREQ-1:0][RCH_W-1:0]  req_ch;

  assign req_vld  = {de_r_valid, o_rvalid};
  assign req_last = {de_r_last, o_rlast};
  assign req_ch   = {de_r_ch, o_rch};

  lock_state_t       lock_q, lock_d;
  logic [IDX_W-1:0]  lidx_q, lidx_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  gidx, cand;
  logic              gvld;
  logic [NREQ-1:0]   grant;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock_q <= LOCK_UNLOCKED;
      lidx_q <= '0;
      rr_q   <= '0;
    end else if (srst) begin
      lock_q <= LOCK_UNLOCKED;
      lidx_q <= '0;
      rr_q   <= '0;
    end else begin
      lock_q <= lock_d;
      lidx_q <= lidx_d;
      rr_q   <= rr_d;
    end
  end

  // Scan from the far end of the rotation back to rr so the candidate
  // nearest rr overwrites the others.
  always_comb begin
    gvld = 1'b0;
    gidx = lidx_q;
    cand = '0;
    if (lock_q == LOCK_LOCKED) begin
      gvld = 1'b1;
    end else begin
      for (int i = NREQ-1; i >= 0; i--) begin
        cand = IDX_W'((int'(rr_q) + i) % NREQ);
        if (req_vld[cand]) begin
          gvld = 1'b1;
          gidx = cand;
        end
      end
    end
    grant = '0;
    if (gvld) grant[gidx] = 1'b1;
  end

  assign o_rready   = {SLV_NB{i_rready}} & grant[SLV_NB-1:0];
  assign de_r_ready = i_rready & grant[SLV_NB];
  assign i_rvalid   = gvld & req_vld[gidx];
  assign i_rlast    = gvld & req_last[gidx];
  assign i_rch      = gvld ? req_ch[gidx] : '0;

  always_comb begin
    lock_d = lock_q;
    lidx_d = lidx_q;
    rr_d   = rr_q;
    if (i_rvalid && i_rready) begin
      if (i_rlast) begin
        lock_d = LOCK_UNLOCKED;
        rr_d   = (gidx == IDX_W'(NREQ-1)) ? '0 : gidx + 1'b1;
      end else begin
        lock_d = LOCK_LOCKED;
        lidx_d = gidx;
      end
    end
  end

endmodule

// File: tb/tb_axicb_slv_switch_rd.sv
// Bench for the slave-side read switch: decode/arbitration vector tables,
// DECERR and reset sequences, and a randomized run against a burst-level model.
module tb_axicb_slv_switch_rd;

  localparam int AW     = 16;
  localparam int IW     = 8;
  localparam int DW     = 8;
  localparam int NS     = 4;
  localparam int ARCH_W = AW + IW + 8;
  localparam int RCH_W  = IW + DW + 2;

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b1;
  logic                    srst = 1'b0;
  logic                    i_arvalid;
  logic                    i_arready;
  logic [ARCH_W-1:0]       i_arch;
  logic                    i_rvalid;
  logic                    i_rready;
  logic                    i_rlast;
  logic [RCH_W-1:0]        i_rch;
  logic [NS-1:0]           o_arvalid;
  logic [NS-1:0]           o_arready;
  logic [ARCH_W-1:0]       o_arch;
  logic [NS-1:0]           o_rvalid;
  logic [NS-1:0]           o_rready;
  logic [NS-1:0]           o_rlast;
  logic [NS*RCH_W-1:0]     o_rch;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axicb_slv_switch_rd #(
    .AXI_ADDR_W (AW),
    .AXI_ID_W   (IW),
    .AXI_DATA_W (DW),
    .SLV_NB     (NS)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .i_arvalid (i_arvalid),
    .i_arready (i_arready),
    .i_arch    (i_arch),
    .i_rvalid  (i_rvalid),
    .i_rready  (i_rready),
    .i_rlast   (i_rlast),
    .i_rch     (i_rch),
    .o_arvalid (o_arvalid),
    .o_arready (o_arready),
    .o_arch    (o_arch),
    .o_rvalid  (o_rvalid),
    .o_rready  (o_rready),
    .o_rlast   (o_rlast),
    .o_rch     (o_rch)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ARCH_W-1:0] mk_ar(input logic [15:0] a, input logic [7:0] id,
                                              input logic [7:0] len);
    return {len, id, a};
  endfunction

  function automatic logic [RCH_W-1:0] slv_ch(input int k, input logic [7:0] d);
    return {2'b00, d, 8'(k)};
  endfunction

  function automatic logic [RCH_W-1:0] de_ch(input logic [7:0] id);
    return {2'b11, 8'h00, id};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_in();
    i_arvalid = 1'b0;
    i_arch    = '0;
    i_rready  = 1'b1;
    o_arready = '0;
    o_rvalid  = '0;
    o_rlast   = '0;
    for (int k = 0; k < NS; k++) o_rch[k*RCH_W +: RCH_W] = slv_ch(k, 8'(16*k + 3));
  endtask

  task automatic sync_clear();
    idle_in();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        v;
    logic [3:0]  ardy;
    logic [3:0]  exp_av;
    logic        exp_rdy;
  } arvec_t;

  typedef struct {
    bit         clr;
    logic [3:0] vld;
    logic [3:0] last;
    logic       exp_vld;
    logic       exp_last;
    logic [3:0] exp_rdy;
    int         src;
  } rvec_t;

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arvec_t av[$];
    rvec_t  rv[$];
    int     beats, lasts, stall_err, fwd_err, data_err, done;
    int     left[NS];
    logic [7:0] dat[NS];
    int     owner, ptr;

    // ---------------- reset state ----------------
    idle_in();
    #1 aresetn = 1'b0;
    #1;
    chk("rst_rvalid", i_rvalid, 1'b0);
    chk("rst_rready", o_rready, 4'b0000);
    chk("rst_rch", i_rch, '0);
    i_arch = mk_ar(16'h8000, 8'h01, 8'h00);
    #1 chk("rst_de_idle_arready", i_arready, 1'b1);
    o_rvalid = 4'b0100;
    #1 chk("rst_rready_slv2", o_rready, 4'b0100);
    idle_in();
    tick();
    tick();
    aresetn = 1'b1;

    // ---------------- AR decode table ----------------
    av.push_back('{16'h1234, 1'b1, 4'b0010, 4'b0010, 1'b1});
    av.push_back('{16'h1234, 1'b1, 4'b1101, 4'b0010, 1'b0});
    av.push_back('{16'h0000, 1'b1, 4'b1111, 4'b0001, 1'b1});
    av.push_back('{16'h0FFF, 1'b1, 4'b0001, 4'b0001, 1'b1});
    av.push_back('{16'h1000, 1'b1, 4'b0001, 4'b0010, 1'b0});
    av.push_back('{16'h3FFF, 1'b1, 4'b1000, 4'b1000, 1'b1});
    av.push_back('{16'h4000, 1'b1, 4'b1111, 4'b0000, 1'b1});
    av.push_back('{16'h2ABC, 1'b0, 4'b0100, 4'b0000, 1'b1});
    av.push_back('{16'hFFFF, 1'b0, 4'b0000, 4'b0000, 1'b1});
    foreach (av[i]) begin
      i_arch    = mk_ar(av[i].addr, 8'(i), 8'h00);
      i_arvalid = av[i].v;
      o_arready = av[i].ardy;
      #1;
      chk($sformatf("ar%0d_arvalid", i), o_arvalid, av[i].exp_av);
      chk($sformatf("ar%0d_arready", i), i_arready, av[i].exp_rdy);
      chk($sformatf("ar%0d_arch", i), o_arch, mk_ar(av[i].addr, 8'(i), 8'h00));
      i_arvalid = 1'b0;
      tick();
    end

    // ---------------- slave 1 four-beat burst ----------------
    sync_clear();
    for (int b = 0; b < 4; b++) begin
      o_rvalid = 4'b0010;
      o_rlast  = (b == 3) ? 4'b0010 : 4'b0000;
      o_rch[RCH_W +: RCH_W] = slv_ch(1, 8'(8'hB0 + b));
      #1;
      chk($sformatf("s1_b%0d_rvalid", b), i_rvalid, 1'b1);
      chk($sformatf("s1_b%0d_rready", b), o_rready, 4'b0010);
      chk($sformatf("s1_b%0d_rch", b), i_rch, slv_ch(1, 8'(8'hB0 + b)));
      chk($sformatf("s1_b%0d_rlast", b), i_rlast, (b == 3));
      tick();
    end

    // ---------------- R arbitration table ----------------
    rv.push_back('{1'b1, 4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0001, 0});
    rv.push_back('{1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0001, 0});
    rv.push_back('{1'b0, 4'b0101, 4'b0001, 1'b1, 1'b1, 4'b0001, 0});
    rv.push_back('{1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 2});
    rv.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 2});
    rv.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, -1});
    rv.push_back('{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 0});
    rv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010, 1});
    rv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 2});
    rv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000, 3});
    rv.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 0});
    foreach (rv[i]) begin
      if (rv[i].clr) sync_clear();
      o_rvalid = rv[i].vld;
      o_rlast  = rv[i].last;
      i_rready = 1'b1;
      #1;
      chk($sformatf("rv%0d_rvalid", i), i_rvalid, rv[i].exp_vld);
      chk($sformatf("rv%0d_rready", i), o_rready, rv[i].exp_rdy);
      if (rv[i].exp_vld) chk($sformatf("rv%0d_rlast", i), i_rlast, rv[i].exp_last);
      chk($sformatf("rv%0d_rch", i), i_rch,
          (rv[i].src < 0) ? '0 : slv_ch(rv[i].src, 8'(16*rv[i].src + 3)));
      tick();
    end

    // ---------------- DECERR, ARLEN=3 ----------------
    sync_clear();
    i_arch    = mk_ar(16'h8000, 8'h5A, 8'd3);
    i_arvalid = 1'b1;
    #1;
    chk("de_arready", i_arready, 1'b1);
    chk("de_no_fwd", o_arvalid, 4'b0000);
    chk("de_not_same_cycle", i_rvalid, 1'b0);
    tick();
    i_arvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("de_b%0d_rvalid", b), i_rvalid, 1'b1);
      chk($sformatf("de_b%0d_rch", b), i_rch, de_ch(8'h5A));
      chk($sformatf("de_b%0d_rlast", b), i_rlast, (b == 3));
      tick();
    end
    #1 chk("de_after_rvalid", i_rvalid, 1'b0);
    tick();

    // ---------------- DECERR, ARLEN=255 with backpressure ----------------
    sync_clear();
    i_arch    = mk_ar(16'hC000, 8'h77, 8'd255);
    i_arvalid = 1'b1;
    #1 chk("de255_arready", i_arready, 1'b1);
    tick();
    beats = 0; lasts = 0; stall_err = 0; fwd_err = 0; data_err = 0; done = 0;
    for (int c = 0; c < 2000 && done == 0; c++) begin
      i_rready = (c % 2 == 0) || ($urandom_range(0, 3) == 0);
      if (c % 2 == 0) begin
        i_arch    = mk_ar(16'h9000, 8'h01, 8'd0);
        o_arready = 4'b0000;
      end else begin
        i_arch    = mk_ar(16'h1234, 8'h02, 8'd0);
        o_arready = 4'b0010;
      end
      i_arvalid = 1'b1;
      #1;
      if (c % 2 == 0 && i_arready) stall_err++;
      if (c % 2 == 1 && !i_arready) fwd_err++;
      if (i_rvalid && i_rready) begin
        beats++;
        if (i_rch !== de_ch(8'h77)) data_err++;
        if (i_rlast) begin
          lasts++;
          done = 1;
        end
      end
      i_arvalid = 1'b0;
      tick();
    end
    chk("de255_done", done, 1);
    chk("de255_beats", beats, 256);
    chk("de255_lasts", lasts, 1);
    chk("de255_stall_err", stall_err, 0);
    chk("de255_fwd_err", fwd_err, 0);
    chk("de255_data_err", data_err, 0);
    i_arch    = mk_ar(16'h9000, 8'h01, 8'd0);
    i_arvalid = 1'b1;
    #1 chk("de255_idle_arready", i_arready, 1'b1);
    i_arvalid = 1'b0;
    tick();

    // ---------------- reset in the middle of a slave-1 burst ----------------
    sync_clear();
    i_arch    = mk_ar(16'hA000, 8'h44, 8'd5);
    i_arvalid = 1'b1;
    o_rvalid  = 4'b0010;
    #1 chk("mb_s1_first", o_rready, 4'b0010);
    tick();
    i_arvalid = 1'b0;
    o_rvalid  = 4'b0011;
    #1 chk("mb_locked_s1", o_rready, 4'b0010);
    aresetn  = 1'b0;
    o_rvalid = 4'b0000;
    #1;
    chk("mb_rst_rvalid", i_rvalid, 1'b0);
    chk("mb_rst_rready", o_rready, 4'b0000);
    i_arch    = mk_ar(16'hA000, 8'h44, 8'd5);
    i_arvalid = 1'b1;
    #1 chk("mb_rst_de_idle", i_arready, 1'b1);
    i_arvalid = 1'b0;
    o_rvalid  = 4'b0011;
    #1 chk("mb_rst_grant0", o_rready, 4'b0001);
    tick();
    tick();
    aresetn = 1'b1;
    #1;
    chk("mb_post_grant0", o_rready, 4'b0001);
    chk("mb_post_rch", i_rch, slv_ch(0, 8'h03));
    idle_in();
    tick();

    // ---------------- randomized run against a burst-level model ----------------
    sync_clear();
    owner = -1;
    ptr   = 0;
    for (int k = 0; k < NS; k++) begin
      left[k] = 0;
      dat[k]  = '0;
    end
    for (int c = 0; c < 1500; c++) begin
      int          eg, sl;
      logic [15:0] a;
      logic [3:0]  exp_rdy, exp_av;
      logic        exp_vld, exp_ardy;
      for (int k = 0; k < NS; k++) begin
        if (left[k] == 0) begin
          left[k] = $urandom_range(1, 4);
          dat[k]  = 8'($urandom);
        end
        o_rvalid[k] = ($urandom_range(0, 9) < 6);
        o_rlast[k]  = (left[k] == 1);
        o_rch[k*RCH_W +: RCH_W] = slv_ch(k, dat[k]);
      end
      i_rready  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      sl        = int'(a) / 4096;
      i_arvalid = (sl < NS) && ($urandom_range(0, 1) == 1);
      o_arready = 4'($urandom);
      i_arch    = mk_ar(a, 8'($urandom), 8'($urandom));

      // A burst owner keeps the port; otherwise the first valid source
      // counting up from the pointer over five slots (responder stays idle).
      eg = owner;
      if (eg < 0) begin
        for (int s = 0; s < NS + 1 && eg < 0; s++) begin
          int q;
          q = (ptr + s) % (NS + 1);
          if (q < NS && o_rvalid[q]) eg = q;
        end
      end
      exp_rdy  = (eg >= 0 && i_rready) ? 4'(1 << eg) : 4'b0000;
      exp_vld  = (eg >= 0) && o_rvalid[eg];
      exp_av   = (i_arvalid && sl < NS) ? 4'(1 << sl) : 4'b0000;
      exp_ardy = (sl < NS) ? o_arready[sl] : 1'b1;
      #1;
      chk("rnd_rready", o_rready, exp_rdy);
      chk("rnd_rvalid", i_rvalid, exp_vld);
      chk("rnd_rch", i_rch, (eg < 0) ? '0 : slv_ch(eg, dat[eg]));
      if (exp_vld) chk("rnd_rlast", i_rlast, (left[eg] == 1));
      chk("rnd_arvalid", o_arvalid, exp_av);
      chk("rnd_arready", i_arready, exp_ardy);

      if (exp_vld && i_rready) begin
        if (left[eg] == 1) begin
          owner = -1;
          ptr   = (eg + 1) % (NS + 1);
        end else begin
          owner = eg;
        end
        left[eg]--;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
